// File: rtl/tqv_periph_pkg.sv
// Shared definitions for the CPU-bus peripherals: register offsets, STATUS
// bit positions, select decode and the UART transmit FSM encoding.
package tqv_periph_pkg;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] DIV_OFF    = 4'h8;

  localparam int STAT_FULL    = 0;
  localparam int STAT_BUSY    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 4;

  localparam logic [1:0] UART_SEL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/tqv_sync_fifo.sv
// Single-clock FIFO with an explicit level count so full and empty stay
// distinct; a push into a full FIFO is taken only when a pop frees a slot.
module tqv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/tqv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU bytes go through a small FIFO and
// are shifted out LSB first at divider+1 clocks per bit.
module tqv_uart_tx
  import tqv_periph_pkg::*;
#(
  parameter int                   FIFO_DEPTH  = 4,
  parameter int                   DIV_WIDTH   = 12,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(103)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [1:0]  write_n,
  input  logic [1:0]  read_n,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  uart_tx_state_t       state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, cnt_q, cnt_d, reload_q, reload_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d, busy_q, ovf_q, ovf_d;

  logic        wr_en, rd_en, push, pop, bit_end;
  logic        f_full, f_empty;
  logic [7:0]  f_head, status;
  logic [AW:0] f_level;
  logic [4:0]  lvl_ext;
  logic        unused_wdata;

  assign wr_en        = sel && (write_n != 2'b11);
  assign rd_en        = sel && (read_n != 2'b11);
  assign push         = wr_en && (addr == TXDATA_OFF);
  assign unused_wdata = &{1'b0, wdata};

  tqv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata[7:0]),
    .rdata_o (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (f_level)
  );

  // Overflow only when the byte is really dropped; a set beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && addr == STATUS_OFF && wdata[STAT_OVF]) ovf_d = 1'b0;
    if (push && f_full && !pop)                         ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    bit_end  = (cnt_q == reload_q);
    case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          pop      = 1'b1;
          shift_d  = f_head;
          reload_d = div_q;
          cnt_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (!f_empty) begin
            pop      = 1'b1;
            shift_d  = f_head;
            reload_d = div_q;
            state_d  = ST_START;
          end else state_d = ST_IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      div_q    <= DEFAULT_DIV;
      cnt_q    <= '0;
      reload_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= !f_empty || (state_q != ST_IDLE);
      ovf_q    <= ovf_d;
      if (wr_en && addr == DIV_OFF) div_q <= wdata[DIV_WIDTH-1:0];
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;

  // Level field is 4 bits; a 16-deep FIFO reports 15 when full.
  assign lvl_ext = 5'(f_level);

  always_comb begin
    status                        = '0;
    status[STAT_FULL]             = f_full;
    status[STAT_BUSY]             = busy_q;
    status[STAT_EMPTY]            = f_empty;
    status[STAT_OVF]              = ovf_q;
    status[STAT_LVL_LSB +: 4]     = lvl_ext[4] ? 4'hF : lvl_ext[3:0];
    rdata = '0;
    if (rd_en) begin
      case (addr)
        STATUS_OFF: rdata = {24'd0, status};
        DIV_OFF:    rdata = 32'(div_q);
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tqv_uart_tx.sv
// Directed bench for the UART transmitter: register map, frame timing,
// back-to-back frames, overflow, push/pop while full and mid-frame reset.
module tb_tqv_uart_tx;
  import tqv_periph_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic [3:0]  addr;
  logic [1:0]  write_n, read_n;
  logic [31:0] wdata, rdata;
  logic        uart_tx, tx_busy;

  int n_chk  = 0;
  int n_fail = 0;

  bit         rx_en = 1'b0;
  int         rx_p  = 1;
  int         rx_ferr = 0;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  tqv_uart_tx dut (
    .clk     (clk),
    .rstn    (rstn),
    .sel     (sel),
    .addr    (addr),
    .write_n (write_n),
    .read_n  (read_n),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  // Reference receiver: samples the first clock of every bit period.
  always begin
    @(posedge clk); #1;
    if (rx_en && uart_tx === 1'b0) begin
      logic [7:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) begin
        repeat (rx_p) @(posedge clk);
        #1 b[k] = uart_tx;
      end
      repeat (rx_p) @(posedge clk);
      #1 if (uart_tx !== 1'b1) rx_ferr++;
      rx_q.push_back(b);
      repeat (rx_p - 1) @(posedge clk);
    end
  end

  function automatic logic exp_line(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; sel = 1'b1; write_n = 2'b00;
    @(posedge clk); #1;
    sel = 1'b0; write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; sel = 1'b1; read_n = 2'b00;
    #1 d = rdata;
    sel = 1'b0; read_n = 2'b11;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rstn = 1'b0; sel = 1'b0; addr = '0; write_n = 2'b11; read_n = 2'b11; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    rstn = 1'b1;
    @(posedge clk); #1;
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h04) begin n_fail++; $display("FAIL reset_status: got %h want 04", d); end
    bus_read(DIV_OFF, d);
    n_chk++; if (d !== 32'd103) begin n_fail++; $display("FAIL reset_div: got %0d want 103", d); end
    bus_read(TXDATA_OFF, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
    bus_read(4'hC, d);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL off_c_read: got %h want 0", d); end
    // Unselected accesses: no read data, no register update.
    addr = DIV_OFF; read_n = 2'b00; sel = 1'b0;
    #1;
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL nosel_read: got %h want 0", rdata); end
    read_n = 2'b11;
    addr = DIV_OFF; wdata = 32'd5; write_n = 2'b00; sel = 1'b0;
    @(posedge clk); #1;
    write_n = 2'b11;
    bus_read(DIV_OFF, d);
    n_chk++; if (d !== 32'd103) begin n_fail++; $display("FAIL nosel_write: got %0d want 103", d); end
  endtask

  task automatic test_single_frame;
    rx_q.delete(); rx_p = 4; rx_en = 1'b1;
    bus_write(DIV_OFF, 32'd3);
    bus_write(TXDATA_OFF, 32'h55);
    @(posedge clk); #1;
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL latency_tx: got %b want 1", uart_tx); end
    n_chk++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy: got %b want 1", tx_busy); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (uart_tx !== exp_line(8'h55, i / 4)) begin
        n_fail++; $display("FAIL frame55_bit%0d: got %b want %b", i, uart_tx, exp_line(8'h55, i / 4));
      end
    end
    @(posedge clk); #1;
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL frame55_busy_end: got %b want 0", tx_busy); end
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame55_idle: got %b want 1", uart_tx); end
    n_chk++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      n_fail++; $display("FAIL frame55_rx: got %0d bytes want 1 byte 55", rx_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    rx_q.delete(); rx_p = 1;
    bus_write(DIV_OFF, 32'd0);
    bus_write(TXDATA_OFF, 32'hA5);
    bus_write(TXDATA_OFF, 32'h3C);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      b = (i < 10) ? 8'hA5 : 8'h3C;
      n_chk++;
      if (uart_tx !== exp_line(b, i % 10)) begin
        n_fail++; $display("FAIL b2b_bit%0d: got %b want %b", i, uart_tx, exp_line(b, i % 10));
      end
    end
    n_chk++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_last_stop: got %b want 1", tx_busy); end
    @(posedge clk); #1;
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_drop: got %b want 0", tx_busy); end
    n_chk++; if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
      n_fail++; $display("FAIL b2b_rx: got %0d bytes want 2 (a5 3c)", rx_q.size());
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    rx_q.delete(); rx_p = 8; rx_ferr = 0;
    bus_write(DIV_OFF, 32'd7);
    for (int i = 1; i <= 6; i++) bus_write(TXDATA_OFF, 32'(8'h11 * i));
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h4B) begin n_fail++; $display("FAIL ovf_status: got %h want 4b", d); end
    bus_write(STATUS_OFF, 32'h8);
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h43) begin n_fail++; $display("FAIL ovf_clear: got %h want 43", d); end
    for (int c = 0; c < 2000 && tx_busy; c++) begin @(posedge clk); #1; end
    n_chk++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: busy %b want 0", tx_busy); end
    n_chk++; if (rx_q.size() != 5) begin n_fail++; $display("FAIL ovf_count: got %0d want 5", rx_q.size()); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== 8'(8'h11 * (i + 1))) begin
        n_fail++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(8'h11 * (i + 1)));
      end
    end
    n_chk++; if (rx_ferr != 0) begin n_fail++; $display("FAIL ovf_framing: got %0d want 0", rx_ferr); end
  endtask

  task automatic test_push_pop_full;
    logic [31:0] d;
    rx_q.delete(); rx_p = 2;
    bus_write(DIV_OFF, 32'd1);
    for (int i = 1; i <= 5; i++) bus_write(TXDATA_OFF, 32'(8'hA0 + i));
    // First frame's stop bit ends 21 edges after the first push: land on it.
    repeat (16) @(posedge clk);
    #1;
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h43) begin n_fail++; $display("FAIL pp_full_before: got %h want 43", d); end
    bus_write(TXDATA_OFF, 32'hA6);
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h43) begin n_fail++; $display("FAIL pp_full_after: got %h want 43", d); end
    for (int c = 0; c < 2000 && tx_busy; c++) begin @(posedge clk); #1; end
    n_chk++; if (rx_q.size() != 6) begin n_fail++; $display("FAIL pp_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      n_chk++;
      if (rx_q[i] !== 8'(8'hA1 + i)) begin
        n_fail++; $display("FAIL pp_byte%0d: got %h want %h", i, rx_q[i], 8'(8'hA1 + i));
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int lows;
    rx_en = 1'b0;
    bus_write(DIV_OFF, 32'd3);
    bus_write(TXDATA_OFF, 32'h00);
    repeat (15) @(posedge clk);
    #1;
    n_chk++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_data_low: got %b want 0", uart_tx); end
    rstn = 1'b0;
    #1;
    n_chk++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
    @(posedge clk); #1;
    rstn = 1'b1;
    bus_read(STATUS_OFF, d);
    n_chk++; if (d !== 32'h04) begin n_fail++; $display("FAIL rst_status: got %h want 04", d); end
    bus_read(DIV_OFF, d);
    n_chk++; if (d !== 32'd103) begin n_fail++; $display("FAIL rst_div: got %0d want 103", d); end
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    n_chk++; if (lows != 0) begin n_fail++; $display("FAIL rst_no_frame: got %0d active cycles want 0", lows); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
